// File: rtl/trace_fmt_pkg.sv
// Shared constants and types for the CPU trace-line formatter.
// ASCII codes, FSM state encoding and the timestamp saturation limit.
package trace_fmt_pkg;

   localparam logic [7:0] CH_CARET  = 8'h5E;
   localparam logic [7:0] CH_AT     = 8'h40;
   localparam logic [7:0] CH_COLON  = 8'h3A;
   localparam logic [7:0] CH_DOLLAR = 8'h24;
   localparam logic [7:0] CH_STAR   = 8'h2A;
   localparam logic [7:0] CH_LT     = 8'h3C;
   localparam logic [7:0] CH_EQ     = 8'h3D;
   localparam logic [7:0] CH_HASH   = 8'h23;
   localparam logic [7:0] CH_SPACE  = 8'h20;
   localparam logic [7:0] CH_0      = 8'h30;
   localparam logic [7:0] CH_LA     = 8'h61;
   localparam logic [7:0] CH_UA     = 8'h41;

   localparam logic [13:0] TIME_SAT = 14'd9999;

   typedef enum logic [3:0] {
      S_IDLE,
      S_CARET,
      S_TIME,
      S_AT,
      S_PC,
      S_COLON,
      S_SP1,
      S_TAG,
      S_GRF,
      S_ADDR,
      S_SP2,
      S_LT,
      S_EQ,
      S_SP3,
      S_DATA,
      S_HASH
   } state_e;

   function automatic logic [7:0] dec_char(input logic [3:0] nib);
      return CH_0 + {4'd0, nib};
   endfunction

   function automatic logic [7:0] hex_char(input logic [3:0] nib,
                                           input logic      upper);
      if (nib < 4'd10) begin
         return CH_0 + {4'd0, nib};
      end
      return (upper ? CH_UA : CH_LA) + {4'd0, nib} - 8'd10;
   endfunction

endpackage

// File: rtl/cpu_trace_formatter_bin_to_bcd.sv
// Combinational double-dabble: 14-bit binary to four BCD digits.
// Also reports the significant digit count (1..4, zero shows as one digit).
module bin_to_bcd (
   input  logic [13:0] bin,
   output logic [15:0] bcd,
   output logic [2:0]  ndig
);

   logic [29:0] sh;

   // Shift-and-add-3 over all input bits, then count significant digits
   always_comb begin
      sh = {16'd0, bin};
      for (int i = 0; i < 14; i++) begin
         for (int k = 0; k < 4; k++) begin
            if (sh[14+4*k +: 4] >= 4'd5) begin
               sh[14+4*k +: 4] = sh[14+4*k +: 4] + 4'd3;
            end
         end
         sh = sh << 1;
      end
      bcd = sh[29:14];
      if (bcd[15:12] != 4'd0) begin
         ndig = 3'd4;
      end else if (bcd[11:8] != 4'd0) begin
         ndig = 3'd3;
      end else if (bcd[7:4] != 4'd0) begin
         ndig = 3'd2;
      end else begin
         ndig = 3'd1;
      end
   end

endmodule

// File: rtl/cpu_trace_formatter.sv
// Serialises one CPU write-back record into an ASCII trace line,
// one character per handshake on the char_valid/char_ready stream.
module cpu_trace_formatter
   import trace_fmt_pkg::*;
#(
   parameter int UPPER_HEX = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_is_mem,
   input  logic [15:0] in_time,
   input  logic [31:0] in_pc,
   input  logic [4:0]  in_grf,
   input  logic [31:0] in_addr,
   input  logic [31:0] in_data,
   output logic [7:0]  char_out,
   output logic        char_valid,
   input  logic        char_ready,
   output logic        busy
);

   localparam logic UPPER = (UPPER_HEX != 0);

   state_e      state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [7:0]  char_q, char_d;
   logic        char_valid_q, char_valid_d;

   logic        is_mem_q, is_mem_d;
   logic [15:0] time_q, time_d;
   logic [31:0] pc_q, pc_d;
   logic [4:0]  grf_q, grf_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] data_q, data_d;

   logic        accept;
   logic        hs;
   logic [13:0] time_sat;
   logic [15:0] t_bcd, g_bcd;
   logic [2:0]  t_ndig, g_ndig;
   logic [3:0][3:0] t_dig, g_dig;
   logic [7:0][3:0] pc_n, addr_n, data_n;

   assign in_ready   = (state_q == S_IDLE);
   assign busy       = ~in_ready;
   assign char_out   = char_q;
   assign char_valid = char_valid_q;

   assign accept = in_valid & in_ready;
   assign hs     = char_valid_q & char_ready;

   assign time_sat = (time_q > {2'b00, TIME_SAT}) ? TIME_SAT
                                                  : time_q[13:0];

   bin_to_bcd u_time_bcd (
      .bin  (time_sat),
      .bcd  (t_bcd),
      .ndig (t_ndig)
   );

   bin_to_bcd u_grf_bcd (
      .bin  ({9'd0, grf_q}),
      .bcd  (g_bcd),
      .ndig (g_ndig)
   );

   assign t_dig  = t_bcd;
   assign g_dig  = g_bcd;
   assign pc_n   = pc_q;
   assign addr_n = addr_q;
   assign data_n = data_q;

   // Capture all record fields on accept; hold them for the whole line
   always_comb begin
      is_mem_d = is_mem_q;
      time_d   = time_q;
      pc_d     = pc_q;
      grf_d    = grf_q;
      addr_d   = addr_q;
      data_d   = data_q;
      if (accept) begin
         is_mem_d = in_is_mem;
         time_d   = in_time;
         pc_d     = in_pc;
         grf_d    = in_grf;
         addr_d   = in_addr;
         data_d   = in_data;
      end
   end

   // Next state and digit counter; counters run MS digit down to 0
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         S_IDLE: begin
            if (accept) state_d = S_CARET;
         end
         S_CARET: if (hs) begin
            state_d = S_TIME;
            cnt_d   = t_ndig - 3'd1;
         end
         S_TIME: if (hs) begin
            if (cnt_q == 3'd0) state_d = S_AT;
            else               cnt_d   = cnt_q - 3'd1;
         end
         S_AT: if (hs) begin
            state_d = S_PC;
            cnt_d   = 3'd7;
         end
         S_PC: if (hs) begin
            if (cnt_q == 3'd0) state_d = S_COLON;
            else               cnt_d   = cnt_q - 3'd1;
         end
         S_COLON: if (hs) state_d = S_SP1;
         S_SP1:   if (hs) state_d = S_TAG;
         S_TAG: if (hs) begin
            if (is_mem_q) begin
               state_d = S_ADDR;
               cnt_d   = 3'd7;
            end else begin
               state_d = S_GRF;
               cnt_d   = g_ndig - 3'd1;
            end
         end
         S_GRF: if (hs) begin
            if (cnt_q == 3'd0) state_d = S_SP2;
            else               cnt_d   = cnt_q - 3'd1;
         end
         S_ADDR: if (hs) begin
            if (cnt_q == 3'd0) state_d = S_SP2;
            else               cnt_d   = cnt_q - 3'd1;
         end
         S_SP2: if (hs) state_d = S_LT;
         S_LT:  if (hs) state_d = S_EQ;
         S_EQ:  if (hs) state_d = S_SP3;
         S_SP3: if (hs) begin
            state_d = S_DATA;
            cnt_d   = 3'd7;
         end
         S_DATA: if (hs) begin
            if (cnt_q == 3'd0) state_d = S_HASH;
            else               cnt_d   = cnt_q - 3'd1;
         end
         S_HASH: if (hs) begin
            state_d = S_IDLE;
            cnt_d   = 3'd0;
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = 3'd0;
         end
      endcase
   end

   // Character for the upcoming state so char_q is a registered output
   always_comb begin
      char_d       = 8'h00;
      char_valid_d = (state_d != S_IDLE);
      unique case (state_d)
         S_IDLE:  char_d = 8'h00;
         S_CARET: char_d = CH_CARET;
         S_TIME:  char_d = dec_char(t_dig[cnt_d[1:0]]);
         S_AT:    char_d = CH_AT;
         S_PC:    char_d = hex_char(pc_n[cnt_d], UPPER);
         S_COLON: char_d = CH_COLON;
         S_SP1:   char_d = CH_SPACE;
         S_TAG:   char_d = is_mem_q ? CH_STAR : CH_DOLLAR;
         S_GRF:   char_d = dec_char(g_dig[cnt_d[1:0]]);
         S_ADDR:  char_d = hex_char(addr_n[cnt_d], UPPER);
         S_SP2:   char_d = CH_SPACE;
         S_LT:    char_d = CH_LT;
         S_EQ:    char_d = CH_EQ;
         S_SP3:   char_d = CH_SPACE;
         S_DATA:  char_d = hex_char(data_n[cnt_d], UPPER);
         S_HASH:  char_d = CH_HASH;
         default: char_d = 8'h00;
      endcase
   end

   // All state flops; reset aborts any line in progress
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         cnt_q        <= 3'd0;
         char_q       <= 8'h00;
         char_valid_q <= 1'b0;
         is_mem_q     <= 1'b0;
         time_q       <= 16'd0;
         pc_q         <= 32'd0;
         grf_q        <= 5'd0;
         addr_q       <= 32'd0;
         data_q       <= 32'd0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         char_q       <= char_d;
         char_valid_q <= char_valid_d;
         is_mem_q     <= is_mem_d;
         time_q       <= time_d;
         pc_q         <= pc_d;
         grf_q        <= grf_d;
         addr_q       <= addr_d;
         data_q       <= data_d;
      end
   end

endmodule

// File: doc/cpu_trace_formatter.md
# cpu_trace_formatter

Transmit-side counterpart of the trace-line checker. Accepts one CPU write-back record per handshake (register write or memory write) and serialises it one ASCII character per cycle. Register lines take the form `^<time>@<pc>: $<grf> <= <data>#`; memory lines take the form `^<time>@<pc>: *<addr> <= <data>#`. Sits between the CPU model's commit port and any character-stream consumer, including the checker itself in loopback benches.

## Interface
- Parameter `UPPER_HEX`, default 0: hex digits are emitted as `a`–`f` when 0, `A`–`F` when 1. The checker accepts lowercase only, so keep 0 in loopback.
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `in_valid` in 1: record present.
- `in_ready` out 1: block can accept a record. High only in IDLE.
- `in_is_mem` in 1: 0 = register record, 1 = memory record.
- `in_time` in 16: decimal timestamp.
- `in_pc` in 32: program counter.
- `in_grf` in 5: register number. Used only when `in_is_mem` = 0.
- `in_addr` in 32: memory address. Used only when `in_is_mem` = 1.
- `in_data` in 32: written value.
- `char` out 8: current ASCII character.
- `char_valid` out 1: `char` is meaningful.
- `char_ready` in 1: consumer takes `char` this cycle.
- `busy` out 1: a line is in progress (`~in_ready`).

## Operation
- Accept: `in_valid & in_ready` at a rising edge. All fields are captured into internal registers; inputs are ignored until the next IDLE.
- Time: emitted in decimal with no leading zeros. Value 0 emits `0`. Values above 9999 saturate to `9999`. Width is 1–4 digits.
- grf: emitted in decimal with no leading zeros, 1–2 digits (0..31).
- pc, addr, data: always exactly 8 hex digits, most significant nibble first, leading zeros kept.
- Spacing: exactly one space after `:`, one space before `<`, one space after `=`.
- FSM states, in order:
  - IDLE → CARET → TIME → AT → PC → COLON → SP1 → TAG
  - TAG → GRF when the record is a register write; TAG → ADDR when it is a memory write
  - GRF/ADDR → SP2 → LT → EQ → SP3 → DATA → HASH → IDLE
- Multi-character states (TIME, PC, GRF, ADDR, DATA) use a 3-bit digit counter. The counter loads on entry and advances on each handshake.
- State or digit advances only on `char_valid & char_ready`.
- Line length: register line = 26 + time digits + grf digits; memory line = 34 + time digits.

## Timing
- Reset values: `char` = 0x00, `char_valid` = 0, `in_ready` = 1, `busy` = 0, FSM in IDLE, digit counter = 0.
- Latency: record accepted at edge T → `^` valid from T+1.
- Throughput: with `char_ready` held high, one character per cycle.
- Backpressure: while `char_ready` = 0, `char` and `char_valid` hold steady with no glitches. `char` never changes while `char_valid & ~char_ready`.
- `char_valid` is 0 in IDLE and 1 in every other state.
- Line end: the handshake on `#` at edge E puts the FSM in IDLE after E, so `in_ready` = 1 in the cycle following E. The next record is accepted at E+1 at the earliest, and its `^` is valid from E+2. This leaves exactly one idle cycle between lines.
- `in_valid` while busy: ignored, no effect.
- Reset mid-line: the line is aborted with no `#` emitted, and all outputs return to reset values after the edge. Reset takes priority over any simultaneous handshake.
- Decimal conversion: combinational from the captured registers. It adds no latency.

## Structure
- Shared package `trace_fmt_pkg`:
  - ASCII constants for `^ @ : $ * < = #`, space, `0`, `a`, `A`.
  - FSM state enum.
  - `TIME_SAT` = 9999.
- Sub-module `bin_to_bcd`: combinational double-dabble, 14-bit input, four 4-bit BCD digits plus a digit-count output. One instance converts time; grf uses the same module with zero-extended input.
- Top level: capture registers, FSM, digit counter, character mux with nibble-to-ASCII conversion.

## Test plan
- **Register line:** time=12, pc=0x00003000, reg, grf=5, data=0xdeadbeef, `char_ready`=1 → emits `^12@00003000: $5 <= deadbeef#`, 29 consecutive `char_valid` cycles starting at T+1, then `in_ready`=1.
- **Memory line and zero time:** time=0, pc=0x00003ffc, mem, addr=0x00000010, data=0 → emits `^0@00003ffc: *00000010 <= 00000000#`, 35 chars.
- **Saturation and two-digit grf:** time=40000, grf=31 → time field `9999`, register field `$31`.
- **Backpressure:** `char_ready` toggled by a pseudo-random pattern → identical character sequence; `char` stable whenever stalled; no character dropped or duplicated.
- **Busy and back-to-back:** `in_valid` held high for two records → second record ignored during line 1, accepted one cycle after `#`, first-record fields unaffected.
- **Reset mid-line:** reset asserted while PC digits are emitting → `char_valid` = 0 and `in_ready` = 1 after the edge; the next record emits a complete, correct line.
